// File: rtl/sr_stream_driver.sv
// Purpose: replay a parallel word bit-serially as {S,R} commands to a downstream SR flop, verifying each bit via q readback.
// Latency: 3 cycles per bit (DRIVE, SETTLE, CHECK); done pulses in the cycle after edge accept+3*WIDTH.
// Backpressure: in_ready is high only in IDLE; in_valid is ignored while a word is being replayed.
module sr_stream_driver #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic [1:0]                   sr,
  input  logic                         q_fb,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [$clog2(WIDTH+1)-1:0]   cmd_count
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(WIDTH);

  localparam logic [1:0] SR_HOLD  = 2'b00;
  localparam logic [1:0] SR_SET   = 2'b10;
  localparam logic [1:0] SR_RESET = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sr_q, sr_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             head;

  // Bit currently being replayed: the end of the shift register selected by MSB_FIRST.
  assign head = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];

  // State and datapath registers; reset abandons any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sr_q    <= SR_HOLD;
      shreg_q <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and command selection; sr defaults to hold so only DRIVE can emit set/reset.
  always_comb begin
    state_d = state_q;
    sr_d    = SR_HOLD;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          shreg_d = in_data;
          idx_d   = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        // An unknown readback falls to the else branch, so the explicit command is issued.
        if (q_fb == head) begin
          sr_d = SR_HOLD;
        end else begin
          sr_d = head ? SR_SET : SR_RESET;
          if (cnt_q != CW'(WIDTH)) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        // An unknown readback is treated as a mismatch.
        if (q_fb == head) begin
          err_d = err_q;
        end else begin
          err_d = 1'b1;
        end
        shreg_d = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
        if (idx_q == IW'(WIDTH - 1)) begin
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = ST_DRIVE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign sr        = sr_q;
  assign err       = err_q;
  assign cmd_count = cnt_q;

endmodule
